// File: rtl/sort_result_collector_pkg.sv
// Shared types and sizing for the sort result collector.
// Frame length, word width and the FSM state encoding live here.
package sort_result_collector_pkg;

   localparam int N       = 10;
   localparam int DW      = 32;
   localparam int AW      = $clog2(N);
   localparam int SW      = DW + AW + 1;
   localparam int MED_IDX = (N - 1) / 2;

   typedef logic signed [DW-1:0] word_t;
   typedef logic signed [SW-1:0] sum_t;
   typedef logic        [AW-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      REPORT  = 2'd2,
      HOLD    = 2'd3
   } state_t;

   function automatic sum_t sext_word(input word_t w);
      return {{(SW - DW){w[DW-1]}}, w};
   endfunction

endpackage

// File: rtl/sort_result_collector_if.sv
// Sorter-output / host read-back bundle for the result collector.
// Signal suffixes are from the collector's point of view.
interface sort_result_collector_if;
   import sort_result_collector_pkg::*;

   logic  ready_i;
   word_t data_i;
   addr_t rd_addr_i;
   word_t rd_data_o;
   logic  busy_o;
   logic  done_o;
   logic  sorted_ok_o;
   logic  frame_err_o;
   word_t min_o;
   word_t max_o;
   word_t median_o;
   sum_t  sum_o;
   addr_t dup_cnt_o;

   modport slave (
      input  ready_i, data_i, rd_addr_i,
      output rd_data_o, busy_o, done_o, sorted_ok_o, frame_err_o,
             min_o, max_o, median_o, sum_o, dup_cnt_o
   );

   modport master (
      output ready_i, data_i, rd_addr_i,
      input  rd_data_o, busy_o, done_o, sorted_ok_o, frame_err_o,
             min_o, max_o, median_o, sum_o, dup_cnt_o
   );

endinterface

// File: rtl/sort_result_collector_frame_buffer.sv
// N-word register file holding the captured frame.
// One write port, a combinational host read port and a fixed median tap.
module sort_result_collector_frame_buffer
   import sort_result_collector_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  we_i,
   input  addr_t wr_addr_i,
   input  word_t wr_data_i,
   input  addr_t rd_addr_i,
   output word_t rd_data_o,
   output word_t med_data_o
);

   word_t mem_w [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_word
         word_t word_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_q <= '0;
            end else if (we_i && (wr_addr_i == addr_t'(gi))) begin
               word_q <= wr_data_i;
            end
         end

         assign mem_w[gi] = word_q;
      end
   endgenerate

   // Addresses past the last word read as zero rather than aliasing.
   assign rd_data_o  = (int'(rd_addr_i) < N) ? mem_w[rd_addr_i] : '0;
   assign med_data_o = mem_w[MED_IDX];

endmodule

// File: rtl/sort_result_collector.sv
// Captures one sorted frame from the serial sorter, checks ordering and
// reports min/max/median/sum/duplicate statistics once the frame completes.
module sort_result_collector
   import sort_result_collector_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   sort_result_collector_if.slave bus
);

   localparam addr_t LAST_IDX = addr_t'(N - 1);

   state_t state_q;
   addr_t  idx_q;
   sum_t   sum_acc_q;
   word_t  prev_q;
   word_t  first_q;
   logic   ok_acc_q;
   addr_t  dup_acc_q;

   logic   busy_q;
   logic   done_q;
   logic   sorted_ok_q;
   logic   frame_err_q;
   word_t  min_q;
   word_t  max_q;
   word_t  median_q;
   sum_t   sum_q;
   addr_t  dup_q;

   logic   buf_we;
   addr_t  buf_addr;
   word_t  buf_med;

   always_comb begin
      buf_we   = 1'b0;
      buf_addr = '0;
      if (bus.ready_i) begin
         if (state_q == IDLE) begin
            buf_we = 1'b1;
         end else if (state_q == CAPTURE) begin
            buf_we   = 1'b1;
            buf_addr = idx_q;
         end
      end
   end

   sort_result_collector_frame_buffer u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (buf_we),
      .wr_addr_i  (buf_addr),
      .wr_data_i  (bus.data_i),
      .rd_addr_i  (bus.rd_addr_i),
      .rd_data_o  (bus.rd_data_o),
      .med_data_o (buf_med)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         sum_acc_q   <= '0;
         prev_q      <= '0;
         first_q     <= '0;
         ok_acc_q    <= 1'b0;
         dup_acc_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sorted_ok_q <= 1'b0;
         frame_err_q <= 1'b0;
         min_q       <= '0;
         max_q       <= '0;
         median_q    <= '0;
         sum_q       <= '0;
         dup_q       <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.ready_i) begin
                  state_q     <= CAPTURE;
                  busy_q      <= 1'b1;
                  idx_q       <= addr_t'(1);
                  sum_acc_q   <= sext_word(bus.data_i);
                  prev_q      <= bus.data_i;
                  first_q     <= bus.data_i;
                  ok_acc_q    <= 1'b1;
                  dup_acc_q   <= '0;
                  frame_err_q <= 1'b0;
               end
            end
            CAPTURE: begin
               if (bus.ready_i) begin
                  sum_acc_q <= sum_acc_q + sext_word(bus.data_i);
                  if (bus.data_i < prev_q) begin
                     ok_acc_q <= 1'b0;
                  end
                  if (bus.data_i == prev_q) begin
                     dup_acc_q <= dup_acc_q + 1'b1;
                  end
                  prev_q <= bus.data_i;
                  idx_q  <= idx_q + 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_q <= REPORT;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  frame_err_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            REPORT: begin
               min_q       <= first_q;
               max_q       <= prev_q;
               median_q    <= buf_med;
               sum_q       <= sum_acc_q;
               dup_q       <= dup_acc_q;
               sorted_ok_q <= ok_acc_q;
               done_q      <= 1'b1;
               // A low ready already seen here counts as the inter-frame gap.
               state_q     <= bus.ready_i ? HOLD : IDLE;
            end
            HOLD: begin
               if (!bus.ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.sorted_ok_o = sorted_ok_q;
   assign bus.frame_err_o = frame_err_q;
   assign bus.min_o       = min_q;
   assign bus.max_o       = max_q;
   assign bus.median_o    = median_q;
   assign bus.sum_o       = sum_q;
   assign bus.dup_cnt_o   = dup_q;

endmodule
